sfifo_ctrl_64_32: RTL
=====================

# sfifo_ctrl_64_32

Synchronous FIFO controller that turns the 64×32 DFF register file into a single-clock FIFO. It sits directly in front of the register file: it drives the write enable, write address, write data and read address, and takes back the registered read data. Upstream producers see a push/full interface, downstream consumers see a pop/valid interface, and both see occupancy status.

## Interface
- ADDR, 6: pointer width; WORDS must equal 2^ADDR.
- WORDS, 64: FIFO depth.
- W_SIZE, 32: data width.
- AF_LEVEL, 56: almost_full asserts when count >= AF_LEVEL.

- fifo_clk  in  1  clock; all logic on rising edge.
- fifo_rst_n  in  1  asynchronous active-low reset.
- push  in  1  write request.
- push_data  in  W_SIZE  write data.
- full  out  1  count == WORDS.
- almost_full  out  1  count >= AF_LEVEL.
- pop  in  1  read request.
- pop_data  out  W_SIZE  read data; valid when pop_valid is high.
- pop_valid  out  1  pop_data holds the word from an accepted pop.
- empty  out  1  count == 0.
- count  out  ADDR+1  current occupancy, 0..WORDS.
- dffs_wen  out  1  register-file write enable.
- dffs_waddr  out  ADDR  register-file write address (wr_ptr).
- dffs_wdata  out  W_SIZE  register-file write data.
- dffs_raddr  out  ADDR  register-file read address (rd_ptr).
- dffs_rdata  in  W_SIZE  registered register-file read data.
- ovf_err, udf_err, err_clr: present only with SFIFO_ERR_FLAG_EN (see Configuration).

## Operation
- Push acceptance: push_acc = push & ~full.
  - dffs_wen = push_acc; dffs_wdata = push_data; dffs_waddr = wr_ptr. All three are combinational.
  - On push_acc, wr_ptr increments by 1 and wraps modulo WORDS.
- Pop acceptance: pop_acc = pop & ~empty.
  - dffs_raddr = rd_ptr, driven from a register.
  - On pop_acc, rd_ptr increments by 1 and wraps modulo WORDS.
- Count update, registered:
  - push_acc only: +1.
  - pop_acc only: −1.
  - Both or neither: unchanged.
- Status flags: full, empty and almost_full are registered and derived from the next count value, so they are exact in the cycle after the update.
- Push while full: dropped, with no pointer or count change. This holds even if pop_acc occurs in the same cycle.
- Pop while empty: ignored. pop_valid stays low in the following cycle.
- pop_data = dffs_rdata (pass-through).
- pop_valid is a register set to pop_acc.
- Reset mid-operation clears wr_ptr, rd_ptr and count to 0. Memory content is not relied upon.

## Timing
- Reset values:
  - count = 0, empty = 1, full = 0, almost_full = 0, pop_valid = 0.
  - dffs_raddr = 0, dffs_waddr = 0, dffs_wen = 0 (push is ignored during reset).
  - pop_data = 0, because the register file resets its read register.
- Push-to-memory: a push accepted in cycle t is written at the end of t. empty deasserts in t+1.
- Pop latency: a pop accepted in cycle t gives pop_valid = 1 in cycle t+1, with pop_data = the word at the old rd_ptr.
  - Back-to-back pops yield one word per cycle.
- Earliest read of a new word: the push is at cycle t and the pop at t+1, so data is returned in t+2. This needs no bypass, because the memory is already written when the read address is sampled.
- Occupancy limits: 64 pushes with no pops leave full = 1 and count = 64. The 65th push is dropped.
- Simultaneous push and pop at 0 < count < WORDS: both are accepted, count is unchanged, and both pointers advance.

## Configuration
- SFIFO_ERR_FLAG_EN defined: adds input err_clr and outputs ovf_err and udf_err.
  - ovf_err sets on push & full.
  - udf_err sets on pop & empty.
  - Both are sticky and reset to 0.
  - err_clr clears them synchronously; a set event in the same cycle as err_clr wins.
- SFIFO_ERR_FLAG_EN undefined: these ports and their logic are absent, and dropped requests are silent.

## Test plan
- Reset → count = 0, empty = 1, full = 0, pop_valid = 0, dffs_wen = 0.
- Push 0x00000000..0x0000003F in 64 consecutive cycles, then pop 64 times back-to-back:
  - almost_full rises after the 56th push; full rises after the 64th.
  - pop_valid is high for 64 consecutive cycles, with pop_data = 0..0x3F in order.
  - empty = 1 at the end.
- With the FIFO full, assert push and pop together with push_data 0xDEADBEEF:
  - The pop is accepted and the push is dropped; count goes 64→63.
  - 0xDEADBEEF is never read out.
  - With SFIFO_ERR_FLAG_EN, ovf_err = 1.
- With the FIFO empty, push 0xA5A5A5A5 at t and pop at t+1 → pop_valid = 1 and pop_data = 0xA5A5A5A5 at t+2.
  - Popping at t instead → ignored; with SFIFO_ERR_FLAG_EN, udf_err = 1.
- Wrap-around: run 200 pushes and pops interleaved at random with count kept within 1..63 → the data order is preserved across pointer wrap, and count always equals pushes minus pops.
- Assert fifo_rst_n low at count = 20 → all outputs return to their reset values immediately. A following push/pop pair returns the new data 1 cycle after the pop.

Source files
------------

// File: rtl/sfifo_ctrl_64_32.sv
// Single-clock FIFO controller wrapping a 64x32 register file with a registered read port.
// Optional sticky overflow/underflow flags are enabled with SFIFO_ERR_FLAG_EN.
module sfifo_ctrl_64_32 #(
    parameter int unsigned ADDR     = 6,
    parameter int unsigned WORDS    = 64,
    parameter int unsigned W_SIZE   = 32,
    parameter int unsigned AF_LEVEL = 56
) (
    input  logic              fifo_clk,
    input  logic              fifo_rst_n,
    // Producer side
    input  logic              push,
    input  logic [W_SIZE-1:0] push_data,
    output logic              full,
    output logic              almost_full,
    // Consumer side
    input  logic              pop,
    output logic [W_SIZE-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic [ADDR:0]     count,
    // Register-file side
    output logic              dffs_wen,
    output logic [ADDR-1:0]   dffs_waddr,
    output logic [W_SIZE-1:0] dffs_wdata,
    output logic [ADDR-1:0]   dffs_raddr,
`ifdef SFIFO_ERR_FLAG_EN
    input  logic              err_clr,
    output logic              ovf_err,
    output logic              udf_err,
`endif
    input  logic [W_SIZE-1:0] dffs_rdata
);

    localparam logic [ADDR:0]   CntWords = (ADDR + 1)'(WORDS);
    localparam logic [ADDR:0]   CntAf    = (ADDR + 1)'(AF_LEVEL);
    localparam logic [ADDR:0]   CntOne   = (ADDR + 1)'(1);
    localparam logic [ADDR-1:0] PtrOne   = ADDR'(1);

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            af_q, af_d;
    logic            pop_valid_q;
    logic            push_acc, pop_acc;

    assign push_acc = push & ~full_q;
    assign pop_acc  = pop & ~empty_q;

    // Qualify with reset so a push held during reset never reaches the register file.
    assign dffs_wen   = push_acc & fifo_rst_n;
    assign dffs_waddr = wr_ptr_q;
    assign dffs_wdata = push_data;
    assign dffs_raddr = rd_ptr_q;

    assign pop_data    = dffs_rdata;
    assign pop_valid   = pop_valid_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they are exact one cycle after the update.
        full_d  = (count_d == CntWords);
        empty_d = (count_d == '0);
        af_d    = (count_d >= CntAf);
    end

    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            pop_valid_q <= pop_acc;
        end
    end

`ifdef SFIFO_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A set event outranks a clear in the same cycle.
    always_comb begin
        ovf_d = (push & full_q) | (ovf_q & ~err_clr);
        udf_d = (pop & empty_q) | (udf_q & ~err_clr);
    end

    always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule
